// File: rtl/banked_sram_ctrl.sv
// banked_sram_ctrl: word-addressed memory built from SLICE_W-wide SRAM banks
// arranged NSLICE wide and NROW deep, accessed over a 4-phase req/ack
// handshake with WAIT access cycles per transfer.
// Optional build macro: UNINIT_CHECK_EN (per-word written flags; reads of
// never-written words return 0 and raise uninit alongside ack).
module banked_sram_ctrl #(
  parameter int SLICE_W = 4,
  parameter int DATA_W  = 16,
  parameter int BANK_AW = 4,
  parameter int ADDR_W  = 6,
  parameter int WAIT    = 2
) (
  input  logic                        clock,
  input  logic                        reset_,
  input  logic                        req,
  input  logic                        we,
  input  logic [ADDR_W-1:0]           addr,
  input  logic [DATA_W-1:0]           wdata,
  input  logic [DATA_W/SLICE_W-1:0]   lane_en,
  output logic                        ack,
  output logic [DATA_W-1:0]           rdata,
  output logic                        busy,
  output logic                        uninit
);

  localparam int NSLICE = DATA_W / SLICE_W;
  localparam int DEPTH  = 1 << BANK_AW;
  localparam int ROW_W  = (ADDR_W > BANK_AW) ? (ADDR_W - BANK_AW) : 1;
  localparam int NROW   = 1 << (ADDR_W - BANK_AW);
  localparam logic [3:0] WAIT_M1 = 4'(WAIT - 1);

  // Illegal geometry or access time stops elaboration.
  if ((DATA_W % SLICE_W) != 0 || WAIT < 1 || WAIT > 15 || ADDR_W < BANK_AW) begin : g_param_err
    $error("banked_sram_ctrl: illegal parameter set");
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_ACK    = 2'd3
  } state_t;

  state_t                    state_q, state_d;
  logic [3:0]                cnt_q, cnt_d;
  logic [DATA_W-1:0]         rdata_q, rdata_d;

  // Operands captured at the request edge; not reset (pure data).
  logic                      we_q, we_d;
  logic [ADDR_W-1:0]         addr_q, addr_d;
  logic [DATA_W-1:0]         wdata_q, wdata_d;
  logic [NSLICE-1:0]         lane_q, lane_d;
  logic [NROW-1:0]           row_sel_q, row_sel_d;

  logic [ROW_W-1:0]          row_idx;
  logic [BANK_AW-1:0]        loc;
  logic [DATA_W-1:0]         rd_word;
  logic                      commit;

  // Bank array: row x slice x location.
  logic [SLICE_W-1:0]        mem_q [NROW][NSLICE][DEPTH];

  if (ADDR_W > BANK_AW) begin : g_row
    assign row_idx = addr_q[ADDR_W-1:BANK_AW];
  end else begin : g_norow
    assign row_idx = '0;
  end

  assign loc = addr_q[BANK_AW-1:0];

  // Read mux: OR together the slices of the one selected row.
  always_comb begin
    rd_word = '0;
    for (int r = 0; r < NROW; r++) begin
      if (row_sel_q[r]) begin
        for (int s = 0; s < NSLICE; s++) begin
          rd_word[s*SLICE_W +: SLICE_W] = rd_word[s*SLICE_W +: SLICE_W] | mem_q[r][s][loc];
        end
      end
    end
  end

`ifdef UNINIT_CHECK_EN
  logic [(1<<ADDR_W)-1:0]    written_q, written_d;
  logic                      uninit_q, uninit_d;
`endif

  // Next-state, operand capture, row decode and read commit.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    lane_d    = lane_q;
    row_sel_d = row_sel_q;
    commit    = 1'b0;
`ifdef UNINIT_CHECK_EN
    written_d = written_q;
    uninit_d  = uninit_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req) begin
          we_d    = we;
          addr_d  = addr;
          wdata_d = wdata;
          lane_d  = lane_en;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        row_sel_d          = '0;
        row_sel_d[row_idx] = 1'b1;
        cnt_d              = WAIT_M1;
        state_d            = S_ACCESS;
      end
      S_ACCESS: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          commit  = 1'b1;
          state_d = S_ACK;
          if (!we_q) begin
            rdata_d = rd_word;
          end
`ifdef UNINIT_CHECK_EN
          if (we_q) begin
            if (lane_q != '0) written_d[addr_q] = 1'b1;
          end else if (!written_q[addr_q]) begin
            rdata_d  = '0;
            uninit_d = 1'b1;
          end
`endif
        end
      end
      S_ACK: begin
        if (!req) begin
          state_d = S_IDLE;
`ifdef UNINIT_CHECK_EN
          uninit_d = 1'b0;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state and read data register, asynchronously reset.
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  // Latched operands and row select.
  always_ff @(posedge clock) begin
    we_q      <= we_d;
    addr_q    <= addr_d;
    wdata_q   <= wdata_d;
    lane_q    <= lane_d;
    row_sel_q <= row_sel_d;
  end

  // Bank write: only the selected row, only enabled slices.
  always_ff @(posedge clock) begin
    if (commit && we_q) begin
      for (int r = 0; r < NROW; r++) begin
        for (int s = 0; s < NSLICE; s++) begin
          if (row_sel_q[r] && lane_q[s]) begin
            mem_q[r][s][loc] <= wdata_q[s*SLICE_W +: SLICE_W];
          end
        end
      end
    end
  end

`ifdef UNINIT_CHECK_EN
  // Written flags and uninit indicator, cleared by reset.
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      written_q <= '0;
      uninit_q  <= 1'b0;
    end else begin
      written_q <= written_d;
      uninit_q  <= uninit_d;
    end
  end

  assign uninit = uninit_q;
`else
  assign uninit = 1'b0;
`endif

  assign ack   = (state_q == S_ACK);
  assign busy  = (state_q != S_IDLE);
  assign rdata = rdata_q;

endmodule

// File: tb/tb_banked_sram_ctrl.sv
// Self-checking bench for banked_sram_ctrl (default parameters, WAIT=2).
// Expected read data comes from a flat word model through a scoreboard queue.
module tb_banked_sram_ctrl;

`ifdef UNINIT_CHECK_EN
  localparam bit UNINIT_ON = 1'b1;
`else
  localparam bit UNINIT_ON = 1'b0;
`endif

  localparam int LAT = 4;  // edges from sampling edge E0 through E(WAIT+1)

  logic        clock = 1'b0;
  logic        reset_ = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [5:0]  addr = '0;
  logic [15:0] wdata = '0;
  logic [3:0]  lane_en = '0;
  logic        ack;
  logic [15:0] rdata;
  logic        busy;
  logic        uninit;

  int checks = 0;
  int errors = 0;

  logic [15:0] mdl  [64];
  bit          flag [64];
  logic [15:0] exp_q [$];
  logic [15:0] last_rd = 16'h0000;

  banked_sram_ctrl dut (
    .clock   (clock),
    .reset_  (reset_),
    .req     (req),
    .we      (we),
    .addr    (addr),
    .wdata   (wdata),
    .lane_en (lane_en),
    .ack     (ack),
    .rdata   (rdata),
    .busy    (busy),
    .uninit  (uninit)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Update the bench model for a write that will commit.
  task automatic model_write(input logic [5:0] a, input logic [15:0] d, input logic [3:0] le);
    for (int s = 0; s < 4; s++) begin
      if (le[s]) mdl[a][s*4 +: 4] = d[s*4 +: 4];
    end
    if (le != 4'b0) flag[a] = 1'b1;
  endtask

  // Wait for ack after the request edge, checking busy and latency; returns edge count.
  task automatic wait_ack(input string tag, output int n);
    n = 0;
    do begin
      @(posedge clock); #1;
      n++;
      if (!ack) chk({tag, "_busy"}, busy, 1'b1);
    end while (!ack && n < 20);
    chk({tag, "_lat"}, n, LAT);
  endtask

  // Check outputs at ack: read data from the scoreboard, or held rdata after a write.
  task automatic check_ack(input logic w, input logic eu);
    logic [15:0] e;
    if (!w) begin
      if (exp_q.size() == 0) begin
        chk("sb_empty", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("rdata", rdata, e);
        last_rd = e;
      end
    end else begin
      chk("rdata_hold", rdata, last_rd);
    end
    chk("uninit", uninit, eu);
  endtask

  task automatic xfer(input logic w, input logic [5:0] a, input logic [15:0] d,
                      input logic [3:0] le, input int hold);
    int n;
    logic eu;
    @(negedge clock);
    req = 1'b1; we = w; addr = a; wdata = d; lane_en = le;
    eu = UNINIT_ON && !w && !flag[a];
    if (!w) exp_q.push_back(eu ? 16'h0000 : mdl[a]);
    else model_write(a, d, le);
    wait_ack("xfer", n);
    check_ack(w, eu);
    for (int i = 0; i < hold; i++) begin
      @(posedge clock); #1;
      chk("ack_hold", ack, 1'b1);
      chk("uninit_hold", uninit, eu);
    end
    req = 1'b0;
    @(posedge clock); #1;
    chk("ack_drop", ack, 1'b0);
    chk("busy_idle", busy, 1'b0);
    chk("uninit_drop", uninit, 1'b0);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 64; i++) begin
      mdl[i]  = 16'h0000;
      flag[i] = 1'b0;
    end

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    chk("rst_ack", ack, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rdata", rdata, 16'h0000);
    chk("rst_uninit", uninit, 1'b0);
    @(negedge clock);
    reset_ = 1'b1;

    // Read of a never-written word (flags only exist with the option built in)
    if (UNINIT_ON) begin
      xfer(1'b0, 6'h3F, 16'h0, 4'h0, 0);
      xfer(1'b1, 6'h3F, 16'h7E81, 4'hF, 0);
      xfer(1'b0, 6'h3F, 16'h0, 4'h0, 0);
    end

    // Basic write/read
    xfer(1'b1, 6'h05, 16'hA5C3, 4'hF, 0);
    xfer(1'b0, 6'h05, 16'h0, 4'h0, 0);

    // Partial lane write merge, and an all-lanes-off no-op write
    xfer(1'b1, 6'h2A, 16'hFFFF, 4'hF, 0);
    xfer(1'b1, 6'h2A, 16'h1234, 4'b0101, 0);
    xfer(1'b0, 6'h2A, 16'h0, 4'h0, 0);
    chk("merge_value", last_rd, 16'hF2F4);
    xfer(1'b1, 6'h2A, 16'h0000, 4'b0000, 0);
    xfer(1'b0, 6'h2A, 16'h0, 4'h0, 0);

    // Row isolation: same bank location, different rows; highest address too
    xfer(1'b1, 6'h03, 16'h1111, 4'hF, 0);
    xfer(1'b1, 6'h13, 16'h2222, 4'hF, 0);
    xfer(1'b1, 6'h33, 16'h4444, 4'hF, 0);
    xfer(1'b1, 6'h23, 16'h3333, 4'b1010, 0);
    xfer(1'b0, 6'h03, 16'h0, 4'h0, 0);
    xfer(1'b0, 6'h13, 16'h0, 4'h0, 0);
    xfer(1'b0, 6'h33, 16'h0, 4'h0, 0);
    xfer(1'b1, 6'h3F, 16'hC0DE, 4'hF, 0);
    xfer(1'b0, 6'h3F, 16'h0, 4'h0, 0);

    // req held 5 cycles past ack: one transfer, then a normal one follows
    xfer(1'b1, 6'h09, 16'h9999, 4'hF, 5);
    xfer(1'b0, 6'h09, 16'h0, 4'h0, 5);
    xfer(1'b0, 6'h05, 16'h0, 4'h0, 0);

    // Operand changes during ACCESS do not affect the latched transfer
    xfer(1'b1, 6'h20, 16'h0F0F, 4'hF, 0);
    @(negedge clock);
    req = 1'b1; we = 1'b1; addr = 6'h10; wdata = 16'h5A5A; lane_en = 4'hF;
    model_write(6'h10, 16'h5A5A, 4'hF);
    @(posedge clock); #1;      // E0
    @(posedge clock); #1;      // E1, now in ACCESS
    addr = 6'h20; wdata = 16'hDEAD; we = 1'b0; lane_en = 4'b0011;
    n = 2;
    while (!ack && n < 20) begin
      @(posedge clock); #1;
      n++;
    end
    chk("chg_lat", n, LAT);
    check_ack(1'b1, 1'b0);
    req = 1'b0;
    @(posedge clock); #1;
    chk("chg_idle", busy, 1'b0);
    xfer(1'b0, 6'h10, 16'h0, 4'h0, 0);
    xfer(1'b0, 6'h20, 16'h0, 4'h0, 0);

    // Reset during ACCESS of a write: no commit, no ack
    xfer(1'b1, 6'h07, 16'h0101, 4'hF, 0);
    @(negedge clock);
    req = 1'b1; we = 1'b1; addr = 6'h07; wdata = 16'hBEEF; lane_en = 4'hF;
    @(posedge clock); #1;      // E0
    @(posedge clock); #1;      // E1, in ACCESS
    chk("pre_rst_ack", ack, 1'b0);
    reset_ = 1'b0;
    #1;
    chk("mid_rst_ack", ack, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_rdata", rdata, 16'h0000);
    req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      chk("rst_hold_ack", ack, 1'b0);
    end
    reset_ = 1'b1;
    last_rd = 16'h0000;
    for (int i = 0; i < 64; i++) flag[i] = 1'b0;
    xfer(1'b1, 6'h11, 16'h0, 4'h0, 0);   // write with no lanes: rdata still reset value
    xfer(1'b0, 6'h07, 16'h0, 4'h0, 0);
    if (!UNINIT_ON) chk("rst_keep_value", last_rd, 16'h0101);

    chk("sb_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
